// File: rtl/scan_pkg.sv
// Shared types and constants for the two-digit scanned seven-segment display.
//   scan_state_t : scan FSM states
//   SEG_BLANK    : all segments off (active-low bus)
//   SEG_GLYPH    : active-low {a,b,c,d,e,f,g} patterns for digits 0-9
//   AN_OFF       : both digit enables off (active-low)
package scan_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ONES  = 3'd1,
        ST_GAP_A = 3'd2,
        ST_TENS  = 3'd3,
        ST_GAP_B = 3'd4
    } scan_state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [1:0] AN_OFF    = 2'b11;

    localparam logic [6:0] SEG_GLYPH [10] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
        7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
    };

endpackage

// File: rtl/seg7_glyph.sv
// Combinational digit-to-glyph lookup for an active-low seven-segment bus.
//   digit : 4-bit value; 0-9 map to their glyph, 10-15 map to blank
//   glyph : active-low {a,b,c,d,e,f,g}
module seg7_glyph
    import scan_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] glyph
);

    // Table lookup, out-of-range digits go dark rather than showing garbage
    always_comb begin
        glyph = SEG_BLANK;
        if (digit < 4'd10) begin
            glyph = SEG_GLYPH[digit];
        end else begin
            glyph = SEG_BLANK;
        end
    end

endmodule

// File: rtl/two_digit_scan_ctrl.sv
// Scan controller for a two-digit common-anode display sharing one segment bus.
// A 0-15 value arrives over valid/ready into a one-deep pending buffer and is
// committed to the displayed value only at the start of a frame, so a frame
// never tears. Each frame: ones digit lit DWELL cycles, GAP dark, tens digit
// lit (or blanked as a leading zero) DWELL cycles, GAP dark.
//   clk, rst_n  : clock, asynchronous active-low reset
//   en          : scan enable; low parks the FSM with the display dark
//   in_valid/in_value/in_ready : value handshake
//   seg         : active-low segments {a..g}, registered
//   an          : active-low digit enables (an[0]=ones, an[1]=tens), registered
//   frame_start : one-cycle pulse with the first ones cycle of each frame
module two_digit_scan_ctrl #(
    parameter int DWELL = 1000,
    parameter int GAP   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       in_valid,
    input  logic [3:0] in_value,
    output logic       in_ready,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       frame_start
);
    import scan_pkg::*;

    localparam int CNT_MAX = (DWELL > GAP) ? DWELL : GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] LD_DWELL = CNT_W'(DWELL);
    localparam logic [CNT_W-1:0] LD_GAP   = CNT_W'(GAP);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    scan_state_t      state_r, state_nxt_s;
    logic [CNT_W-1:0] cnt_r, cnt_val_s;
    logic             cnt_load_s;
    logic [3:0]       pend_r, cur_r, cur_nxt_s, ones_s;
    logic             pend_v_r;
    logic             enter_ones_s, xfer_s;
    logic [6:0]       ones_glyph_s, seg_r, seg_nxt_s;
    logic [1:0]       an_r, an_nxt_s;
    logic             fs_r;

    assign in_ready     = !pend_v_r;
    assign xfer_s       = in_valid && !pend_v_r;
    assign enter_ones_s = (state_nxt_s == ST_ONES) && (state_r != ST_ONES);
    // Value the display will show after this edge (commit happens on ONES entry)
    assign cur_nxt_s    = (enter_ones_s && pend_v_r) ? pend_r : cur_r;
    assign ones_s       = (cur_nxt_s >= 4'd10) ? (cur_nxt_s - 4'd10) : cur_nxt_s;

    seg7_glyph u_ones_glyph (
        .digit (ones_s),
        .glyph (ones_glyph_s)
    );

    // Next-state logic; every state entry reloads the dwell counter
    always_comb begin
        state_nxt_s = state_r;
        cnt_load_s  = 1'b0;
        cnt_val_s   = LD_DWELL;
        if (!en) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_nxt_s = ST_ONES;
                    cnt_load_s  = 1'b1;
                    cnt_val_s   = LD_DWELL;
                end
                ST_ONES: begin
                    if (cnt_r == CNT_ONE) begin
                        state_nxt_s = ST_GAP_A;
                        cnt_load_s  = 1'b1;
                        cnt_val_s   = LD_GAP;
                    end else begin
                        state_nxt_s = ST_ONES;
                    end
                end
                ST_GAP_A: begin
                    if (cnt_r == CNT_ONE) begin
                        state_nxt_s = ST_TENS;
                        cnt_load_s  = 1'b1;
                        cnt_val_s   = LD_DWELL;
                    end else begin
                        state_nxt_s = ST_GAP_A;
                    end
                end
                ST_TENS: begin
                    if (cnt_r == CNT_ONE) begin
                        state_nxt_s = ST_GAP_B;
                        cnt_load_s  = 1'b1;
                        cnt_val_s   = LD_GAP;
                    end else begin
                        state_nxt_s = ST_TENS;
                    end
                end
                ST_GAP_B: begin
                    if (cnt_r == CNT_ONE) begin
                        state_nxt_s = ST_ONES;
                        cnt_load_s  = 1'b1;
                        cnt_val_s   = LD_DWELL;
                    end else begin
                        state_nxt_s = ST_GAP_B;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // Output decode from the next state so seg/an register on the state edge
    always_comb begin
        seg_nxt_s = SEG_BLANK;
        an_nxt_s  = AN_OFF;
        case (state_nxt_s)
            ST_ONES: begin
                seg_nxt_s = ones_glyph_s;
                an_nxt_s  = 2'b10;
            end
            ST_TENS: begin
                // Leading-zero blanking keeps TENS timing, just stays dark
                if (cur_nxt_s >= 4'd10) begin
                    seg_nxt_s = SEG_GLYPH[1];
                    an_nxt_s  = 2'b01;
                end else begin
                    seg_nxt_s = SEG_BLANK;
                    an_nxt_s  = AN_OFF;
                end
            end
            default: begin
                seg_nxt_s = SEG_BLANK;
                an_nxt_s  = AN_OFF;
            end
        endcase
    end

    // State and dwell counter; counter holds at 1 instead of wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= LD_DWELL;
        end else begin
            state_r <= state_nxt_s;
            if (cnt_load_s) begin
                cnt_r <= cnt_val_s;
            end else if (cnt_r > CNT_ONE) begin
                cnt_r <= cnt_r - CNT_ONE;
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    // Pending buffer and displayed value; a transfer is only possible when
    // pend is empty, so it never collides with a commit of real data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_r   <= 4'd0;
            pend_v_r <= 1'b0;
            cur_r    <= 4'd0;
        end else begin
            cur_r <= cur_nxt_s;
            if (xfer_s) begin
                pend_r   <= in_value;
                pend_v_r <= 1'b1;
            end else if (enter_ones_s) begin
                pend_v_r <= 1'b0;
            end else begin
                pend_v_r <= pend_v_r;
            end
        end
    end

    // Registered display outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_r <= SEG_BLANK;
            an_r  <= AN_OFF;
            fs_r  <= 1'b0;
        end else begin
            seg_r <= seg_nxt_s;
            an_r  <= an_nxt_s;
            fs_r  <= enter_ones_s;
        end
    end

    assign seg         = seg_r;
    assign an          = an_r;
    assign frame_start = fs_r;

endmodule
